// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game-play core.
package hangman_pkg;
    localparam int LETTER_W      = 5;
    localparam int WORD_LEN      = 6;
    localparam int NUM_LETTERS   = 26;
    localparam int MAX_LIVES_DEF = 6;
    localparam logic [LETTER_W-1:0] BLANK_CODE = 5'd31;

    typedef logic [LETTER_W-1:0]                letter_t;
    typedef logic [WORD_LEN-1:0][LETTER_W-1:0]  word_t;
    typedef logic [NUM_LETTERS-1:0]             mask_t;
    typedef logic [WORD_LEN-1:0]                slots_t;
    typedef logic [3:0]                         lives_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CHECK,
        ST_WON,
        ST_LOST
    } state_t;

    // Slot i occupies word bits [5i+4:5i].
    function automatic letter_t slot_of(input word_t w, input int i);
        return w[i];
    endfunction
endpackage

// File: rtl/guess_checker_if.sv
// Round-setup and letter-strobe bundle between selector/decoder and the guess checker.
interface guess_checker_if;
    logic                    new_round;
    hangman_pkg::word_t      word;
    hangman_pkg::mask_t      word_mask;
    logic                    letter_valid;
    hangman_pkg::letter_t    letter;
    logic                    ready;
    hangman_pkg::slots_t     revealed;
    hangman_pkg::mask_t      guessed;
    hangman_pkg::lives_t     lives_left;
    logic                    hit;
    logic                    miss;
    logic                    repeat_guess;
    logic                    game_won;
    logic                    game_lost;

    modport master (
        output new_round, word, word_mask, letter_valid, letter,
        input  ready, revealed, guessed, lives_left, hit, miss, repeat_guess,
               game_won, game_lost
    );

    modport slave (
        input  new_round, word, word_mask, letter_valid, letter,
        output ready, revealed, guessed, lives_left, hit, miss, repeat_guess,
               game_won, game_lost
    );
endinterface

// File: rtl/letter_match.sv
// Per-slot comparator: match[i] is set when slot i of word holds letter.
module letter_match
    import hangman_pkg::*;
(
    input  word_t   word,
    input  letter_t letter,
    output slots_t  match
);
    for (genvar i = 0; i < WORD_LEN; i++) begin : g_slot
        assign match[i] = (slot_of(word, i) == letter);
    end
endmodule

// File: rtl/guess_checker.sv
// Hangman game-play core: latches the round's word, scores letter strobes,
// tracks revealed slots / guessed letters / lives and reports win or loss.
module guess_checker
    import hangman_pkg::*;
#(
    parameter int MAX_LIVES = MAX_LIVES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    guess_checker_if.slave  gif
);
    localparam lives_t LIVES_INIT = lives_t'(MAX_LIVES);

    state_t  state, state_d;
    word_t   word_q, word_d;
    mask_t   mask_q, mask_d;
    letter_t letter_q, letter_d;
    slots_t  revealed_q, revealed_d;
    mask_t   guessed_q, guessed_d;
    lives_t  lives_q, lives_d;
    logic    hit_q, hit_d;
    logic    miss_q, miss_d;
    logic    rep_q, rep_d;

    slots_t  blank_slots;
    slots_t  hit_slots;

    // Unused slots are pre-revealed at round start.
    letter_match u_blank_match (
        .word   (gif.word),
        .letter (BLANK_CODE),
        .match  (blank_slots)
    );

    letter_match u_guess_match (
        .word   (word_q),
        .letter (letter_q),
        .match  (hit_slots)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_q     <= '1;
            mask_q     <= '0;
            letter_q   <= '0;
            revealed_q <= '0;
            guessed_q  <= '0;
            lives_q    <= LIVES_INIT;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            state      <= state_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            letter_q   <= letter_d;
            revealed_q <= revealed_d;
            guessed_q  <= guessed_d;
            lives_q    <= lives_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            rep_q      <= rep_d;
        end
    end

    always_comb begin
        state_d    = state;
        word_d     = word_q;
        mask_d     = mask_q;
        letter_d   = letter_q;
        revealed_d = revealed_q;
        guessed_d  = guessed_q;
        lives_d    = lives_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        rep_d      = 1'b0;

        if (gif.new_round) begin
            word_d     = gif.word;
            mask_d     = gif.word_mask;
            revealed_d = blank_slots;
            guessed_d  = '0;
            lives_d    = LIVES_INIT;
            state_d    = ST_PLAY;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (gif.letter_valid && (gif.letter < letter_t'(NUM_LETTERS))) begin
                        letter_d = gif.letter;
                        state_d  = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (guessed_q[letter_q]) begin
                        rep_d = 1'b1;
                    end else begin
                        guessed_d[letter_q] = 1'b1;
                        if (mask_q[letter_q]) begin
                            hit_d      = 1'b1;
                            revealed_d = revealed_q | hit_slots;
                        end else begin
                            miss_d  = 1'b1;
                            lives_d = (lives_q == '0) ? '0 : lives_q - 4'd1;
                        end
                    end
                    // Outcome judged on the post-update values.
                    if (&revealed_d)          state_d = ST_WON;
                    else if (lives_d == '0)   state_d = ST_LOST;
                    else                      state_d = ST_PLAY;
                end
                default: ;
            endcase
        end
    end

    assign gif.ready        = (state == ST_PLAY);
    assign gif.revealed     = revealed_q;
    assign gif.guessed      = guessed_q;
    assign gif.lives_left   = lives_q;
    assign gif.hit          = hit_q;
    assign gif.miss         = miss_q;
    assign gif.repeat_guess = rep_q;
    assign gif.game_won     = (state == ST_WON);
    assign gif.game_lost    = (state == ST_LOST);
endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker: one task per scenario, hand-computed expectations.
module tb_guess_checker;
    import hangman_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    guess_checker_if gif();

    guess_checker #(.MAX_LIVES(6)) dut (
        .clk   (clk),
        .reset (reset),
        .gif   (gif.slave)
    );

    always #5 clk = ~clk;

    // "CAT": C=2, A=0, T=19 in slots 0..2, slots 3..5 unused.
    localparam word_t CAT_WORD  = {5'd31, 5'd31, 5'd31, 5'd19, 5'd0, 5'd2};
    localparam mask_t CAT_MASK  = 26'h0080005;
    localparam word_t BLANK_WORD = '1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input word_t w, input mask_t m);
        gif.word      = w;
        gif.word_mask = m;
        gif.new_round = 1'b1;
        tick();
        gif.new_round = 1'b0;
    endtask

    // Strobe sampled on the next edge; returns during the CHECK cycle.
    task automatic strobe(input letter_t l);
        gif.letter       = l;
        gif.letter_valid = 1'b1;
        tick();
        gif.letter_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        gif.new_round = 1'b1;
        gif.word = CAT_WORD;
        gif.word_mask = CAT_MASK;
        tick();
        tick();
        gif.new_round = 1'b0;
        vectors++; if (gif.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", gif.ready); end
        vectors++; if (gif.revealed !== 6'b0) begin errors++; $display("FAIL reset_revealed: got %b want 000000", gif.revealed); end
        vectors++; if (gif.guessed !== 26'h0) begin errors++; $display("FAIL reset_guessed: got %h want 0", gif.guessed); end
        vectors++; if (gif.lives_left !== 4'd6) begin errors++; $display("FAIL reset_lives: got %0d want 6", gif.lives_left); end
        vectors++; if ({gif.hit, gif.miss, gif.repeat_guess, gif.game_won, gif.game_lost} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 00000",
                {gif.hit, gif.miss, gif.repeat_guess, gif.game_won, gif.game_lost}); end
        reset = 1'b0;
        tick();
        vectors++; if (gif.ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", gif.ready); end
    endtask

    task automatic test_hit_repeat();
        start_round(CAT_WORD, CAT_MASK);
        vectors++; if (gif.revealed !== 6'b111000) begin errors++; $display("FAIL round_revealed: got %b want 111000", gif.revealed); end
        vectors++; if (gif.lives_left !== 4'd6) begin errors++; $display("FAIL round_lives: got %0d want 6", gif.lives_left); end
        vectors++; if (gif.ready !== 1'b1) begin errors++; $display("FAIL round_ready: got %b want 1", gif.ready); end
        strobe(5'd0);
        vectors++; if (gif.ready !== 1'b0 || gif.hit !== 1'b0) begin errors++; $display("FAIL check_cycle: ready=%b hit=%b want 0 0", gif.ready, gif.hit); end
        tick();
        vectors++; if (gif.hit !== 1'b1) begin errors++; $display("FAIL hit_A: got %b want 1", gif.hit); end
        vectors++; if (gif.revealed !== 6'b111010) begin errors++; $display("FAIL reveal_A: got %b want 111010", gif.revealed); end
        vectors++; if (gif.guessed !== 26'h1) begin errors++; $display("FAIL guessed_A: got %h want 1", gif.guessed); end
        vectors++; if (gif.ready !== 1'b1) begin errors++; $display("FAIL ready_after_A: got %b want 1", gif.ready); end
        tick();
        vectors++; if (gif.hit !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b want 0", gif.hit); end
        strobe(5'd0);
        tick();
        vectors++; if (gif.repeat_guess !== 1'b1 || gif.hit !== 1'b0) begin errors++; $display("FAIL repeat_A: rep=%b hit=%b want 1 0", gif.repeat_guess, gif.hit); end
        vectors++; if (gif.lives_left !== 4'd6) begin errors++; $display("FAIL repeat_lives: got %0d want 6", gif.lives_left); end
    endtask

    task automatic test_win();
        strobe(5'd2);
        tick();
        vectors++; if (gif.revealed !== 6'b111011 || gif.game_won !== 1'b0) begin errors++; $display("FAIL reveal_C: rev=%b won=%b want 111011 0", gif.revealed, gif.game_won); end
        strobe(5'd19);
        tick();
        vectors++; if (gif.game_won !== 1'b1 || gif.ready !== 1'b0) begin errors++; $display("FAIL won_T: won=%b ready=%b want 1 0", gif.game_won, gif.ready); end
        vectors++; if (gif.revealed !== 6'b111111) begin errors++; $display("FAIL reveal_T: got %b want 111111", gif.revealed); end
        strobe(5'd16);
        tick();
        vectors++; if (gif.guessed !== 26'h0080005 || gif.hit !== 1'b0 || gif.miss !== 1'b0)
            begin errors++; $display("FAIL won_ignore_Q: guessed=%h hit=%b miss=%b want 0080005 0 0", gif.guessed, gif.hit, gif.miss); end
        vectors++; if (gif.game_won !== 1'b1) begin errors++; $display("FAIL won_held: got %b want 1", gif.game_won); end
    endtask

    task automatic test_lose();
        letter_t misses [6] = '{5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        start_round(CAT_WORD, CAT_MASK);
        vectors++; if (gif.game_won !== 1'b0) begin errors++; $display("FAIL won_cleared: got %b want 0", gif.game_won); end
        for (int k = 0; k < 6; k++) begin
            strobe(misses[k]);
            tick();
            vectors++; if (gif.miss !== 1'b1 || gif.lives_left !== 4'(5 - k))
                begin errors++; $display("FAIL miss_%0d: miss=%b lives=%0d want 1 %0d", k, gif.miss, gif.lives_left, 5 - k); end
        end
        vectors++; if (gif.game_lost !== 1'b1 || gif.ready !== 1'b0) begin errors++; $display("FAIL lost: lost=%b ready=%b want 1 0", gif.game_lost, gif.ready); end
        strobe(5'd8);
        tick();
        vectors++; if (gif.lives_left !== 4'd0 || gif.miss !== 1'b0 || gif.guessed[8] !== 1'b0)
            begin errors++; $display("FAIL lost_ignore: lives=%0d miss=%b g8=%b want 0 0 0", gif.lives_left, gif.miss, gif.guessed[8]); end
    endtask

    task automatic test_new_round_collisions();
        gif.letter = 5'd0;
        gif.letter_valid = 1'b1;
        start_round(CAT_WORD, CAT_MASK);
        gif.letter_valid = 1'b0;
        vectors++; if (gif.ready !== 1'b1 || gif.lives_left !== 4'd6 || gif.game_lost !== 1'b0)
            begin errors++; $display("FAIL nr_letter: ready=%b lives=%0d lost=%b want 1 6 0", gif.ready, gif.lives_left, gif.game_lost); end
        tick();
        vectors++; if (gif.guessed !== 26'h0 || gif.hit !== 1'b0) begin errors++; $display("FAIL nr_letter_dropped: guessed=%h hit=%b want 0 0", gif.guessed, gif.hit); end
        strobe(5'd1);
        start_round(CAT_WORD, CAT_MASK);
        vectors++; if (gif.miss !== 1'b0 || gif.lives_left !== 4'd6 || gif.guessed !== 26'h0 || gif.ready !== 1'b1)
            begin errors++; $display("FAIL nr_in_check: miss=%b lives=%0d guessed=%h ready=%b want 0 6 0 1",
                gif.miss, gif.lives_left, gif.guessed, gif.ready); end
    endtask

    task automatic test_back_to_back();
        strobe(5'd0);
        gif.letter = 5'd2;
        gif.letter_valid = 1'b1;
        tick();
        gif.letter_valid = 1'b0;
        vectors++; if (gif.hit !== 1'b1 || gif.revealed !== 6'b111010) begin errors++; $display("FAIL b2b_first: hit=%b rev=%b want 1 111010", gif.hit, gif.revealed); end
        tick();
        vectors++; if (gif.guessed !== 26'h1 || gif.ready !== 1'b1 || gif.hit !== 1'b0)
            begin errors++; $display("FAIL b2b_dropped: guessed=%h ready=%b hit=%b want 1 1 0", gif.guessed, gif.ready, gif.hit); end
    endtask

    task automatic test_invalid_code();
        strobe(5'd27);
        vectors++; if (gif.ready !== 1'b1) begin errors++; $display("FAIL code27_ready: got %b want 1", gif.ready); end
        tick();
        vectors++; if (gif.guessed !== 26'h1 || gif.miss !== 1'b0 || gif.repeat_guess !== 1'b0)
            begin errors++; $display("FAIL code27_ignored: guessed=%h miss=%b rep=%b want 1 0 0", gif.guessed, gif.miss, gif.repeat_guess); end
    endtask

    task automatic test_reset_mid_check();
        strobe(5'd2);
        reset = 1'b1;
        gif.new_round = 1'b1;
        tick();
        reset = 1'b0;
        gif.new_round = 1'b0;
        vectors++; if (gif.ready !== 1'b0 || gif.revealed !== 6'b0 || gif.guessed !== 26'h0 || gif.lives_left !== 4'd6 || gif.hit !== 1'b0)
            begin errors++; $display("FAIL reset_mid_check: ready=%b rev=%b guessed=%h lives=%0d hit=%b want 0 0 0 6 0",
                gif.ready, gif.revealed, gif.guessed, gif.lives_left, gif.hit); end
    endtask

    task automatic test_blank_word();
        start_round(BLANK_WORD, 26'h0);
        vectors++; if (gif.revealed !== 6'b111111 || gif.ready !== 1'b1) begin errors++; $display("FAIL blank_round: rev=%b ready=%b want 111111 1", gif.revealed, gif.ready); end
        strobe(5'd5);
        tick();
        vectors++; if (gif.miss !== 1'b1 || gif.lives_left !== 4'd5 || gif.game_won !== 1'b1 || gif.game_lost !== 1'b0)
            begin errors++; $display("FAIL blank_won: miss=%b lives=%0d won=%b lost=%b want 1 5 1 0",
                gif.miss, gif.lives_left, gif.game_won, gif.game_lost); end
    endtask

    initial begin
        reset            = 1'b1;
        gif.new_round    = 1'b0;
        gif.word         = '1;
        gif.word_mask    = '0;
        gif.letter_valid = 1'b0;
        gif.letter       = '0;
        test_reset();
        test_hit_repeat();
        test_win();
        test_lose();
        test_new_round_collisions();
        test_back_to_back();
        test_invalid_code();
        test_reset_mid_check();
        test_blank_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
Game-play core of the hangman design; sits directly downstream of the level selector and keyboard decoder.
Latches the 6-slot word and alphabet mask that the level selector publishes at round start. Consumes decoded letter strobes (0..25 = A..Z) and tracks revealed slots, already-guessed letters and remaining lives. Reports win/loss back to the level selector through won/lost flags.

Parameters:
MAX_LIVES, 6, lives at round start (1..15)
WORD_LEN, 6, letter slots in the word
LETTER_W, 5, bits per letter code

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
new_round  input  1  one-cycle pulse; latch word/mask and start a round
word  input  WORD_LEN*LETTER_W (30)  slot i at bits [5i+4:5i]; code 31 = unused slot
word_mask  input  26  bit k set iff letter k occurs in word
letter_valid  input  1  one-cycle strobe, letter is a new key press
letter  input  LETTER_W  decoded letter code
ready  output  1  high only in PLAY; strobes outside PLAY are dropped
revealed  output  WORD_LEN  bit i set = slot i shown
guessed  output  26  letters already tried this round
lives_left  output  4  remaining lives
hit  output  1  one-cycle pulse: new correct letter
miss  output  1  one-cycle pulse: new wrong letter
repeat_guess  output  1  one-cycle pulse: letter already guessed
game_won  output  1  level, held until new_round/reset
game_lost  output  1  level, held until new_round/reset

Behaviour:
- Reset: state IDLE; revealed=0, guessed=0, lives_left=MAX_LIVES; all pulses and flags 0; ready=0; latched word=all-31, latched mask=0.
- States: IDLE, PLAY, CHECK, WON, LOST.
- new_round is checked first in every state, including mid-CHECK:
  - latch word and word_mask;
  - revealed[i] = (slot i == 31), so unused slots are pre-revealed;
  - guessed=0, lives_left=MAX_LIVES, flags cleared;
  - next state PLAY.
- new_round with letter_valid in the same cycle: new_round wins and the letter is dropped.
- PLAY: on letter_valid with letter<26, register the letter and go to CHECK. Codes 26..31 are ignored and the state stays PLAY.
- CHECK (exactly one cycle):
  - guessed[letter]=1 → repeat_guess pulse; no other change.
  - else if mask[letter]=1 → hit pulse; guessed[letter]<=1; revealed <= revealed | match. match[i] = (slot i == letter), from letter_match.
  - else → miss pulse; guessed[letter]<=1; lives_left<=lives_left-1.
  - Next state, evaluated on the updated values: all revealed → WON; else lives_left==0 → LOST; else PLAY.
- Latency: letter_valid sampled at edge n → pulse, updated revealed/guessed/lives and new state visible after edge n+1. ready is low for that one CHECK cycle.
- Back-to-back strobes: a strobe arriving during CHECK is dropped; no queueing.
- lives_left never underflows; a miss is only possible while lives_left≥1.
- WON: game_won=1, ready=0; all letters ignored until new_round or reset. LOST is the same with game_lost=1.
- Upstream guarantees word_mask is consistent with word. A mask/word mismatch yields a hit with no newly revealed slot and is not checked.
- An all-blank word (all slots 31) goes PLAY → WON on the first accepted non-repeat guess.
- reset in any state overrides everything, including new_round.

Decomposition:
- hangman_pkg: LETTER_W, WORD_LEN, NUM_LETTERS=26, BLANK_CODE=31, MAX_LIVES default, state enum, slot-extract helper function.
- Sub-module letter_match: combinational; inputs word and letter, output WORD_LEN match vector. Reused by the display stage.

Test Plan:
- Word "CAT" (slots 0..2 = 2,0,19; slots 3..5 = 31), mask bits {0,2,19}, new_round → revealed=6'b111000, lives=6, ready=1.
- Guess 'A' (0) → hit one cycle after strobe, revealed=6'b111010, guessed bit0 set; guess 'A' again → repeat_guess, lives still 6.
- Guesses C, T → game_won=1 after the T check cycle, ready=0; further strobe 'Q' → no change.
- Six misses (B,D,E,F,G,H) → lives 5..0, game_lost=1 after the sixth; a seventh strobe is ignored.
- new_round and letter_valid in the same cycle, and new_round during CHECK → round restarts cleanly, letter dropped, lives=6.
- Strobe with code 27 → ignored; reset asserted mid-CHECK → IDLE with all outputs at reset values on the next cycle.
